// File: rtl/mmem_writeback_pkg.sv
// mmem_pkg: shared types and defaults for the M scratchpad writeback slice.
// Optional parity storage is enabled with MMEM_PARITY_EN.
package mmem_pkg;

    localparam int MM_AW = 5;
    localparam int MM_DW = 32;

    typedef enum logic {
        MM_IDLE,
        MM_PEND
    } mm_state_t;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mmem_writeback_if.sv
// M-control request/response bundle between the sequencer and the scratchpad.
// master = M control, slave = mmem_writeback.
interface mmem_writeback_if #(
    parameter int AW = mmem_pkg::MM_AW,
    parameter int DW = mmem_pkg::MM_DW
);

    logic          mrp;
    logic [AW-1:0] madr;
    logic          mwp;
    logic [AW-1:0] wadr;
    logic [DW-1:0] l;
    logic [DW-1:0] mf;
    logic          mvalid;
    logic          mpass;
    logic          busy;
    logic          merr;

    modport master (
        output mrp, madr, mwp, wadr, l,
        input  mf, mvalid, mpass, busy, merr
    );

    modport slave (
        input  mrp, madr, mwp, wadr, l,
        output mf, mvalid, mpass, busy, merr
    );

endinterface

// File: rtl/mmem_writeback_ram.sv
// mmem_ram: single-port synchronous RAM, one access per cycle.
// Kept as a separate module so a technology macro can replace it.
module mmem_ram #(
    parameter int AW = 5,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end else begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/mmem_writeback.sv
// M scratchpad responder: single-port RAM, one-entry write buffer, read pass-around.
// Define MMEM_PARITY_EN to store even parity per word and flag a sticky merr.
module mmem_writeback
    import mmem_pkg::*;
#(
    parameter int AW = MM_AW,
    parameter int DW = MM_DW
) (
    input  logic            clk,
    input  logic            reset,
    mmem_writeback_if.slave m
);

`ifdef MMEM_PARITY_EN
    localparam int RW = DW + 1;
`else
    localparam int RW = DW;
`endif

    mm_state_t     state_q;
    mm_state_t     state_d;
    logic [AW-1:0] padr_q;
    logic [AW-1:0] padr_d;
    logic [DW-1:0] pdata_q;
    logic [DW-1:0] pdata_d;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [RW-1:0] ram_din;
    logic [RW-1:0] ram_dout;

    logic          hit_w;
    logic          hit_p;
    logic          pass_d;
    logic [DW-1:0] fwd_d;

    logic          rd_q;
    logic          pass_q;
    logic [DW-1:0] fwd_q;
    logic [DW-1:0] mf_q;
    logic [DW-1:0] mf_now;

    assign hit_w = m.mwp && (m.wadr == m.madr);
    assign hit_p = (state_q == MM_PEND) && (padr_q == m.madr);

    // Same-cycle write beats the buffered one; both beat the RAM.
    assign pass_d = m.mrp && (hit_w || hit_p);
    assign fwd_d  = hit_w ? m.l : pdata_q;

    always_comb begin
        state_d   = state_q;
        padr_d    = padr_q;
        pdata_d   = pdata_q;
        ram_addr  = m.madr;
        ram_we    = 1'b0;
        ram_wdata = m.l;
        unique case (state_q)
            MM_IDLE: begin
                if (m.mwp && m.mrp) begin
                    state_d = MM_PEND;
                    padr_d  = m.wadr;
                    pdata_d = m.l;
                end else if (m.mwp) begin
                    ram_we   = 1'b1;
                    ram_addr = m.wadr;
                end
            end
            MM_PEND: begin
                if (!m.mrp) begin
                    ram_we    = 1'b1;
                    ram_addr  = padr_q;
                    ram_wdata = pdata_q;
                    if (m.mwp) begin
                        padr_d  = m.wadr;
                        pdata_d = m.l;
                    end else begin
                        state_d = MM_IDLE;
                    end
                end else if (m.mwp && (m.wadr == padr_q)) begin
                    pdata_d = m.l;
                end
            end
            default: state_d = MM_IDLE;
        endcase
        // A write buffered at reset time is dropped, never committed.
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MM_IDLE;
            padr_q  <= '0;
            pdata_q <= '0;
            rd_q    <= 1'b0;
            pass_q  <= 1'b0;
            fwd_q   <= '0;
            mf_q    <= '0;
        end else begin
            state_q <= state_d;
            padr_q  <= padr_d;
            pdata_q <= pdata_d;
            rd_q    <= m.mrp;
            pass_q  <= pass_d;
            if (pass_d) begin
                fwd_q <= fwd_d;
            end
            if (rd_q) begin
                mf_q <= mf_now;
            end
        end
    end

    mmem_ram #(
        .AW (AW),
        .W  (RW)
    ) u_ram (
        .clk  (clk),
        .addr (ram_addr),
        .we   (ram_we),
        .din  (ram_din),
        .dout (ram_dout)
    );

    // RAM dout is the read register; mf_q only holds it between reads.
    assign mf_now   = pass_q ? fwd_q : ram_dout[DW-1:0];
    assign m.mf     = rd_q ? mf_now : mf_q;
    assign m.mvalid = rd_q;
    assign m.mpass  = pass_q;
    assign m.busy   = (state_q == MM_PEND);

`ifdef MMEM_PARITY_EN
    logic merr_q;
    logic par_err;

    assign ram_din = {parity(64'(ram_wdata)), ram_wdata};
    assign par_err = rd_q && !pass_q && (^ram_dout);

    always_ff @(posedge clk) begin
        if (reset) begin
            merr_q <= 1'b0;
        end else if (par_err) begin
            merr_q <= 1'b1;
        end
    end

    assign m.merr = merr_q | par_err;
`else
    assign ram_din = ram_wdata;
    assign m.merr  = 1'b0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && (state_q == MM_PEND) && m.mrp && m.mwp) begin
            assert (m.wadr == padr_q)
            else $error("mmem overflow");
        end
    end
`endif

endmodule

// File: tb/tb_mmem_writeback.sv
// Self-checking bench for mmem_writeback against a word-level scratchpad model.
// Build with MMEM_PARITY_EN to include the parity error scenario.
module tb_mmem_writeback;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mmem_writeback_if #(.AW(5), .DW(32)) m ();

    mmem_writeback dut (
        .clk   (clk),
        .reset (reset),
        .m     (m)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: committed contents plus at most one not-yet-committed write.
    logic [31:0] ram_ref [32];
    bit          pv;
    logic [4:0]  pa;
    logic [31:0] pd;

    logic [31:0] e_mf;
    logic        e_valid;
    logic        e_pass;
    logic        e_busy;

    task automatic drive(input bit r, input logic [4:0] ra,
                         input bit w, input logic [4:0] wa,
                         input logic [31:0] d);
        e_valid = r;
        e_pass  = 1'b0;
        if (r) begin
            if (w && wa == ra) begin
                e_mf = d; e_pass = 1'b1;
            end else if (pv && pa == ra) begin
                e_mf = pd; e_pass = 1'b1;
            end else begin
                e_mf = ram_ref[ra];
            end
        end
        if (!r) begin
            if (pv) begin
                ram_ref[pa] = pd;
                if (w) begin pa = wa; pd = d; end
                else pv = 1'b0;
            end else if (w) begin
                ram_ref[wa] = d;
            end
        end else if (w) begin
            if (!pv) begin pv = 1'b1; pa = wa; pd = d; end
            else if (wa == pa) pd = d;
        end
        e_busy = pv;
        m.mrp  = r;
        m.madr = ra;
        m.mwp  = w;
        m.wadr = wa;
        m.l    = d;
        @(posedge clk);
        #1;
        m.mrp = 1'b0;
        m.mwp = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m.mrp = 1'b0;
        m.mwp = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pv = 1'b0;
        e_mf = '0; e_valid = 1'b0; e_pass = 1'b0; e_busy = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (m.mf !== 32'h0) begin errors++; $display("FAIL reset_mf got=%h exp=0", m.mf); end checks++;
        if (m.mvalid !== 1'b0) begin errors++; $display("FAIL reset_mvalid got=%b exp=0", m.mvalid); end checks++;
        if (m.mpass !== 1'b0) begin errors++; $display("FAIL reset_mpass got=%b exp=0", m.mpass); end checks++;
        if (m.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", m.busy); end checks++;
        if (m.merr !== 1'b0) begin errors++; $display("FAIL reset_merr got=%b exp=0", m.merr); end checks++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 32; i++) begin
            drive(0, 5'd0, 1, 5'(i), 32'(i) * 32'h01010101);
            if (m.busy !== 1'b0) begin errors++; $display("FAIL fill_busy[%0d] got=%b exp=0", i, m.busy); end checks++;
        end
        for (int i = 0; i < 32; i++) begin
            drive(1, 5'(i), 0, 5'd0, 32'h0);
            if (m.mvalid !== 1'b1) begin errors++; $display("FAIL b2b_mvalid[%0d] got=%b exp=1", i, m.mvalid); end checks++;
            if (m.mf !== 32'(i) * 32'h01010101) begin errors++; $display("FAIL b2b_mf[%0d] got=%h exp=%h", i, m.mf, 32'(i) * 32'h01010101); end checks++;
            if (m.mf !== e_mf) begin errors++; $display("FAIL b2b_model[%0d] got=%h exp=%h", i, m.mf, e_mf); end checks++;
        end
        drive(0, 5'd0, 0, 5'd0, 32'h0);
        if (m.mvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle_mvalid got=%b exp=0", m.mvalid); end checks++;
        if (m.mf !== 32'h1F1F1F1F) begin errors++; $display("FAIL b2b_hold_mf got=%h exp=1f1f1f1f", m.mf); end checks++;
    endtask

    task automatic test_direct_write();
        drive(0, 5'd0, 1, 5'd5, 32'hDEADBEEF);
        if (m.busy !== 1'b0) begin errors++; $display("FAIL dw_busy0 got=%b exp=0", m.busy); end checks++;
        drive(0, 5'd0, 0, 5'd0, 32'h0);
        if (m.busy !== 1'b0) begin errors++; $display("FAIL dw_busy1 got=%b exp=0", m.busy); end checks++;
        drive(1, 5'd5, 0, 5'd0, 32'h0);
        if (m.mf !== 32'hDEADBEEF) begin errors++; $display("FAIL dw_mf got=%h exp=deadbeef", m.mf); end checks++;
        if (m.mpass !== 1'b0) begin errors++; $display("FAIL dw_mpass got=%b exp=0", m.mpass); end checks++;
        if (m.mvalid !== 1'b1) begin errors++; $display("FAIL dw_mvalid got=%b exp=1", m.mvalid); end checks++;
    endtask

    task automatic test_pass_around();
        drive(1, 5'd7, 1, 5'd7, 32'h12345678);
        if (m.mf !== 32'h12345678) begin errors++; $display("FAIL pa_mf got=%h exp=12345678", m.mf); end checks++;
        if (m.mpass !== 1'b1) begin errors++; $display("FAIL pa_mpass got=%b exp=1", m.mpass); end checks++;
        if (m.busy !== 1'b1) begin errors++; $display("FAIL pa_busy got=%b exp=1", m.busy); end checks++;
        drive(0, 5'd0, 0, 5'd0, 32'h0);
        if (m.busy !== 1'b0) begin errors++; $display("FAIL pa_commit_busy got=%b exp=0", m.busy); end checks++;
        if (m.mpass !== 1'b0) begin errors++; $display("FAIL pa_idle_mpass got=%b exp=0", m.mpass); end checks++;
        drive(1, 5'd7, 0, 5'd0, 32'h0);
        if (m.mf !== 32'h12345678) begin errors++; $display("FAIL pa_ram_mf got=%h exp=12345678", m.mf); end checks++;
        if (m.mpass !== 1'b0) begin errors++; $display("FAIL pa_ram_mpass got=%b exp=0", m.mpass); end checks++;
    endtask

    task automatic test_conflict();
        drive(0, 5'd0, 1, 5'd9, 32'h1);
        drive(1, 5'd9, 1, 5'd3, 32'hA5A5A5A5);
        if (m.mf !== 32'h1) begin errors++; $display("FAIL cf_mf0 got=%h exp=1", m.mf); end checks++;
        if (m.mpass !== 1'b0) begin errors++; $display("FAIL cf_mpass0 got=%b exp=0", m.mpass); end checks++;
        if (m.busy !== 1'b1) begin errors++; $display("FAIL cf_busy0 got=%b exp=1", m.busy); end checks++;
        drive(1, 5'd3, 0, 5'd0, 32'h0);
        if (m.mf !== 32'hA5A5A5A5) begin errors++; $display("FAIL cf_mf1 got=%h exp=a5a5a5a5", m.mf); end checks++;
        if (m.mpass !== 1'b1) begin errors++; $display("FAIL cf_mpass1 got=%b exp=1", m.mpass); end checks++;
        drive(0, 5'd0, 0, 5'd0, 32'h0);
        drive(1, 5'd3, 0, 5'd0, 32'h0);
        if (m.mf !== 32'hA5A5A5A5) begin errors++; $display("FAIL cf_mf2 got=%h exp=a5a5a5a5", m.mf); end checks++;
    endtask

    task automatic test_reset_pending();
        logic [31:0] old4;
        drive(0, 5'd0, 0, 5'd0, 32'h0);
        old4 = ram_ref[4];
        drive(1, 5'd0, 1, 5'd4, 32'hCAFEF00D);
        if (m.busy !== 1'b1) begin errors++; $display("FAIL rp_busy_pre got=%b exp=1", m.busy); end checks++;
        do_reset();
        if (m.busy !== 1'b0) begin errors++; $display("FAIL rp_busy got=%b exp=0", m.busy); end checks++;
        if (m.mf !== 32'h0) begin errors++; $display("FAIL rp_mf got=%h exp=0", m.mf); end checks++;
        if (m.mvalid !== 1'b0) begin errors++; $display("FAIL rp_mvalid got=%b exp=0", m.mvalid); end checks++;
        drive(0, 5'd0, 0, 5'd0, 32'h0);
        drive(1, 5'd4, 0, 5'd0, 32'h0);
        if (m.mf !== old4) begin errors++; $display("FAIL rp_old_mf got=%h exp=%h", m.mf, old4); end checks++;
        if (m.mpass !== 1'b0) begin errors++; $display("FAIL rp_mpass got=%b exp=0", m.mpass); end checks++;
    endtask

    task automatic test_random();
        bit          r;
        bit          w;
        logic [4:0]  ra;
        logic [4:0]  wa;
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 2) != 0);
            w  = ($urandom_range(0, 1) != 0);
            ra = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 3));
            wa = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 3));
            if (r && w && pv && wa != pa) wa = pa;
            drive(r, ra, w, wa, $urandom);
            if (m.mvalid !== e_valid) begin errors++; $display("FAIL rnd_mvalid[%0d] got=%b exp=%b", n, m.mvalid, e_valid); end checks++;
            if (m.mf !== e_mf) begin errors++; $display("FAIL rnd_mf[%0d] got=%h exp=%h", n, m.mf, e_mf); end checks++;
            if (m.mpass !== e_pass) begin errors++; $display("FAIL rnd_mpass[%0d] got=%b exp=%b", n, m.mpass, e_pass); end checks++;
            if (m.busy !== e_busy) begin errors++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", n, m.busy, e_busy); end checks++;
            if (m.merr !== 1'b0) begin errors++; $display("FAIL rnd_merr[%0d] got=%b exp=0", n, m.merr); end checks++;
        end
        drive(0, 5'd0, 0, 5'd0, 32'h0);
        drive(0, 5'd0, 0, 5'd0, 32'h0);
    endtask

`ifdef MMEM_PARITY_EN
    task automatic test_parity();
        drive(0, 5'd0, 0, 5'd0, 32'h0);
        dut.u_ram.mem[2][0] = ~dut.u_ram.mem[2][0];
        drive(1, 5'd2, 0, 5'd0, 32'h0);
        if (m.merr !== 1'b1) begin errors++; $display("FAIL par_merr got=%b exp=1", m.merr); end checks++;
        drive(0, 5'd0, 0, 5'd0, 32'h0);
        drive(1, 5'd0, 0, 5'd0, 32'h0);
        if (m.merr !== 1'b1) begin errors++; $display("FAIL par_sticky got=%b exp=1", m.merr); end checks++;
        do_reset();
        if (m.merr !== 1'b0) begin errors++; $display("FAIL par_reset got=%b exp=0", m.merr); end checks++;
    endtask
`endif

    initial begin
        m.mrp  = 1'b0;
        m.madr = '0;
        m.mwp  = 1'b0;
        m.wadr = '0;
        m.l    = '0;
        for (int i = 0; i < 32; i++) ram_ref[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_direct_write();
        test_pass_around();
        test_conflict();
        test_reset_pending();
        test_random();
`ifdef MMEM_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mmem_writeback.md
Name: mmem_writeback

Overview:
- Responder side of the M-control interface.
- Owns the 32-word x 32-bit M scratchpad, built on a single-port synchronous RAM.
- Accepts read strobes (mrp with madr) and write strobes (mwp with wadr and L data) as issued by M control.
- Holds each write in a one-entry pending buffer until a free RAM cycle. Forwards the pending or just-written word to reads of the same address (M pass-around), so the datapath never sees stale M data.

Parameters:
- AW, 5, M address width (depth = 2**AW = 32).
- DW, 32, data word width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- mrp  input  1  read strobe; valid during STATE_DECODE.
- madr  input  AW  read address, sampled when mrp=1.
- mwp  input  1  write strobe; valid during STATE_WRITE.
- wadr  input  AW  write address, sampled when mwp=1.
- l  input  DW  write data, sampled when mwp=1.
- mf  output  DW  M read data, registered; valid one cycle after mrp.
- mvalid  output  1  one-cycle pulse, aligned with mf update.
- mpass  output  1  mf came from the pending buffer, not the RAM (debug/visibility).
- busy  output  1  pending write not yet committed.
- merr  output  1  sticky parity error (only with MMEM_PARITY_EN; otherwise tied 0).

Behaviour:
- Reset values: mf=0, mvalid=0, mpass=0, busy=0, merr=0, pending buffer invalid. RAM contents are not cleared.
- Reset mid-operation discards any pending write; that write is lost by design.
- FSM states:
  - IDLE (no pending write).
  - PEND (pending buffer holds {padr, pdata}).
- IDLE, mwp=1, mrp=0: write the RAM directly this cycle. Stay in IDLE.
- IDLE, mwp=1, mrp=1: the read owns the RAM port. Capture {wadr, l} into the buffer and go to PEND.
- PEND, mrp=0: commit the buffer to the RAM and go to IDLE. If mwp=1 in the same cycle, capture the new write into the buffer and stay in PEND.
- PEND, mrp=1: the read owns the port and the buffer holds. If mwp=1 in the same cycle, that is an overflow:
  - Commit the old buffer is impossible, so the new write overwrites the buffer only when wadr==padr.
  - Otherwise assert the sim-only assertion "mmem overflow". The sequencer guarantees at most one write per two cycles, so this case is illegal.
- busy = (state==PEND).
- Read latency is 1 cycle: mf and mvalid update on the clock edge after mrp=1.
- Read forwarding priority, highest first:
  1. Same-cycle mwp with wadr==madr: return l, mpass=1 (write-then-read pass-around).
  2. Pending valid and padr==madr: return pdata, mpass=1.
  3. Otherwise return the RAM word, mpass=0.
- When mrp=0, mf holds its last value, mvalid=0, mpass=0.
- Address arithmetic: addresses are exact AW-bit compares; no wrap or offset.
- Address 0 is an ordinary location with no special meaning.

Optional Feature:
- Macro: MMEM_PARITY_EN.
- Defined:
  - RAM is DW+1 wide and stores even parity of the data on every write.
  - On a RAM-sourced read (mpass=0), a parity mismatch sets merr, which stays set until reset.
  - Forwarded reads are not checked.
- Undefined: RAM is DW wide, no parity logic, merr tied 0.

Decomposition:
- Shared package mmem_pkg holds:
  - AW/DW defaults.
  - State enum {MM_IDLE, MM_PEND}.
  - parity function.
- One sub-module: mmem_ram, a single-port synchronous RAM (address, we, din, dout, width parameter), so technology RAMs can be swapped in.

Test Plan:
- Write wadr=5, l=32'hDEADBEEF with mrp=0; read madr=5 two cycles later -> mf=32'hDEADBEEF, mpass=0, busy never set.
- Same cycle mwp wadr=7 l=32'h12345678 and mrp madr=7 -> next cycle mf=32'h12345678, mpass=1, busy=1. Following cycle with mrp=0 -> busy=0; a later read of 7 returns the same value with mpass=0.
- Conflict write wadr=3 l=32'hA5A5A5A5 with mrp madr=9 (RAM[9]=32'h1), then mrp madr=3 next cycle -> first mf=1 mpass=0, second mf=32'hA5A5A5A5 mpass=1.
- Pending write at wadr=4, then assert reset for 1 cycle -> all outputs 0, busy=0; a read of 4 returns the old RAM value.
- Back-to-back reads of addresses 0..31 after filling RAM[i]=i*32'h01010101 -> mvalid pulses every cycle and each mf matches, including address 31.
- MMEM_PARITY_EN defined: force a bit flip in RAM[2] via backdoor, read 2 -> merr=1 and sticky; reset clears it.
